// File: rtl/gcm_job_ctrl.sv
// Job sequencer between a host and a GCM engine: latches one job, pulses the engine, collects ct/tag, holds the response.
// Optional WAIT watchdog: define GCM_JOB_CTRL_TIMEOUT_EN to bound the engine wait by TIMEOUT_CYCLES.
module gcm_job_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [95:0]  req_iv,
    input  logic [127:0] req_aad,
    input  logic [127:0] req_pt,
    input  logic [63:0]  req_aad_size,
    input  logic [63:0]  req_pt_size,
    output logic         eng_new,
    output logic [127:0] eng_key,
    output logic [95:0]  eng_iv,
    output logic [127:0] eng_aad,
    output logic [127:0] eng_pt,
    output logic [63:0]  eng_aad_size,
    output logic [63:0]  eng_pt_size,
    input  logic         eng_cp_ready,
    input  logic [127:0] eng_ct,
    input  logic         eng_tag_ready,
    input  logic [127:0] eng_tag,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ct,
    output logic [127:0] rsp_tag,
    output logic         rsp_err,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic          req_ready_r, eng_new_r, rsp_valid_r, busy_r;
    logic          req_ready_s, eng_new_s, rsp_valid_s, busy_s;
    logic          ct_got_r, tag_got_r;
    logic [127:0]  ct_cap_r, tag_cap_r;
    logic [127:0]  key_r, aad_r, pt_r;
    logic [95:0]   iv_r;
    logic [63:0]   aad_size_r, pt_size_r;
    logic          req_fire_s, complete_s, timeout_s;

    assign req_fire_s = req_valid && req_ready_r;
    // A result pulse in the same cycle counts toward completion, so simultaneous arrival leaves WAIT at once.
    assign complete_s = (ct_got_r || eng_cp_ready) && (tag_got_r || eng_tag_ready);

`ifdef GCM_JOB_CTRL_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    logic        rsp_err_r;

    // Watchdog fires on the last allowed WAIT cycle only if results are still missing.
    always_comb begin
        timeout_s = (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 32'd1)) && !complete_s;
    end

    // WAIT-cycle counter, restarted for every launched job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == LAUNCH) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end

    // Error flag lives for the DONE phase of a timed-out job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_r <= 1'b0;
        end else if (state_r == WAIT && timeout_s) begin
            rsp_err_r <= 1'b1;
        end else if (state_r == DONE && rsp_ready) begin
            rsp_err_r <= 1'b0;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    logic cfg_unused_s;

    assign timeout_s    = 1'b0;
    assign cfg_unused_s = (TIMEOUT_CYCLES > 32'd1);
    assign rsp_err      = 1'b0;
`endif

    // State and handshake-output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            eng_new_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= req_ready_s;
            eng_new_r   <= eng_new_s;
            rsp_valid_r <= rsp_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_fire_s) state_s = LAUNCH;
                else            state_s = IDLE;
            end
            LAUNCH: state_s = WAIT;
            WAIT: begin
                if (complete_s || timeout_s) state_s = DONE;
                else                         state_s = WAIT;
            end
            DONE: begin
                if (rsp_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state they describe.
    always_comb begin
        req_ready_s = (state_s == IDLE);
        eng_new_s   = (state_s == LAUNCH);
        rsp_valid_s = (state_s == DONE);
        busy_s      = (state_s != IDLE);
    end

    // Job operands, loaded only on an accepted request so they hold through LAUNCH/WAIT/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r      <= 128'd0;
            iv_r       <= 96'd0;
            aad_r      <= 128'd0;
            pt_r       <= 128'd0;
            aad_size_r <= 64'd0;
            pt_size_r  <= 64'd0;
        end else if (req_fire_s) begin
            key_r      <= req_key;
            iv_r       <= req_iv;
            aad_r      <= req_aad;
            pt_r       <= req_pt;
            aad_size_r <= req_aad_size;
            pt_size_r  <= req_pt_size;
        end
    end

    // Engine result capture; later pulses overwrite, and a timeout zeroes whatever partial result was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ct_got_r  <= 1'b0;
            tag_got_r <= 1'b0;
            ct_cap_r  <= 128'd0;
            tag_cap_r <= 128'd0;
        end else if (state_r == WAIT) begin
            if (eng_cp_ready) begin
                ct_got_r <= 1'b1;
                ct_cap_r <= eng_ct;
            end
            if (eng_tag_ready) begin
                tag_got_r <= 1'b1;
                tag_cap_r <= eng_tag;
            end
            if (timeout_s) begin
                ct_cap_r  <= 128'd0;
                tag_cap_r <= 128'd0;
            end
        end else if (state_r == DONE && rsp_ready) begin
            ct_got_r  <= 1'b0;
            tag_got_r <= 1'b0;
            ct_cap_r  <= 128'd0;
            tag_cap_r <= 128'd0;
        end
    end

    assign req_ready    = req_ready_r;
    assign eng_new      = eng_new_r;
    assign busy         = busy_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_ct       = ct_cap_r;
    assign rsp_tag      = tag_cap_r;
    assign eng_key      = key_r;
    assign eng_iv       = iv_r;
    assign eng_aad      = aad_r;
    assign eng_pt       = pt_r;
    assign eng_aad_size = aad_size_r;
    assign eng_pt_size  = pt_size_r;
endmodule

// File: tb/tb_gcm_job_ctrl.sv
// Scoreboard bench for gcm_job_ctrl: randomized jobs and engine pulse schedules against a reference model.
module tb_gcm_job_ctrl;
`ifdef GCM_JOB_CTRL_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam bit TMO_EN     = 1'b1;
`else
    localparam int TB_TIMEOUT = 1024;
    localparam bit TMO_EN     = 1'b0;
`endif
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0, req_ready;
    logic [127:0] req_key = '0, req_aad = '0, req_pt = '0;
    logic [95:0]  req_iv = '0;
    logic [63:0]  req_aad_size = '0, req_pt_size = '0;
    logic         eng_new;
    logic [127:0] eng_key, eng_aad, eng_pt;
    logic [95:0]  eng_iv;
    logic [63:0]  eng_aad_size, eng_pt_size;
    logic         eng_cp_ready = 1'b0, eng_tag_ready = 1'b0;
    logic [127:0] eng_ct = '0, eng_tag = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [127:0] rsp_ct, rsp_tag;

    gcm_job_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_iv(req_iv), .req_aad(req_aad), .req_pt(req_pt),
        .req_aad_size(req_aad_size), .req_pt_size(req_pt_size),
        .eng_new(eng_new), .eng_key(eng_key), .eng_iv(eng_iv), .eng_aad(eng_aad),
        .eng_pt(eng_pt), .eng_aad_size(eng_aad_size), .eng_pt_size(eng_pt_size),
        .eng_cp_ready(eng_cp_ready), .eng_ct(eng_ct), .eng_tag_ready(eng_tag_ready),
        .eng_tag(eng_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ct(rsp_ct), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] tag;
        logic         err;
    } rsp_t;

    int           checks = 0;
    int           errors = 0;
    logic [607:0] op_q[$];
    rsp_t         rsp_q[$];
    logic [607:0] last_op = '0;

    // Job operands and engine pulse schedule for the next job.
    logic [127:0] op_key, op_aad, op_pt;
    logic [95:0]  op_iv;
    logic [63:0]  op_aad_size, op_pt_size;
    bit           s_ct_v[W];
    bit           s_tag_v[W];
    logic [127:0] s_ct_d[W];
    logic [127:0] s_tag_d[W];

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic random_ops();
        op_key = rand128(); op_aad = rand128(); op_pt = rand128();
        op_iv = rand128()[95:0];
        op_aad_size = {$urandom, $urandom}; op_pt_size = {$urandom, $urandom};
    endtask

    task automatic clear_sched();
        for (int w = 0; w < W; w++) begin
            s_ct_v[w] = 1'b0; s_tag_v[w] = 1'b0;
            s_ct_d[w] = rand128(); s_tag_d[w] = rand128();
        end
    endtask

    task automatic random_sched();
        clear_sched();
        for (int w = 0; w < W; w++) begin
            s_ct_v[w]  = ($urandom_range(0, 3) == 0);
            s_tag_v[w] = ($urandom_range(0, 3) == 0);
        end
        s_ct_v[$urandom_range(0, 5)]  = 1'b1;
        s_tag_v[$urandom_range(0, 5)] = 1'b1;
    endtask

    // Reference: the result is the latest value of each kind seen by the first cycle in which
    // both kinds have been seen; otherwise the watchdog ends the wait with an all-zero error response.
    task automatic model(output rsp_t e, output int wc);
        bit seen_c = 1'b0, seen_t = 1'b0;
        e.ct = '0; e.tag = '0; e.err = 1'b0; wc = -1;
        for (int w = 0; w < W; w++) begin
            if (s_ct_v[w])  begin seen_c = 1'b1; e.ct  = s_ct_d[w];  end
            if (s_tag_v[w]) begin seen_t = 1'b1; e.tag = s_tag_d[w]; end
            if (seen_c && seen_t) begin wc = w; break; end
            if (TMO_EN && w == TB_TIMEOUT - 1) begin
                e.ct = '0; e.tag = '0; e.err = 1'b1; wc = w; break;
            end
        end
    endtask

    task automatic issue_req();
        int guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        chk("req_ready_wait", 640'(req_ready), 640'(1'b1));
        op_q.push_back({op_key, op_iv, op_aad, op_pt, op_aad_size, op_pt_size});
        req_valid = 1'b1;
        req_key = op_key; req_iv = op_iv; req_aad = op_aad; req_pt = op_pt;
        req_aad_size = op_aad_size; req_pt_size = op_pt_size;
        tick();
        req_valid = 1'b0;
        req_key = rand128(); req_pt = rand128();
        chk("eng_new_launch", 640'(eng_new), 640'(1'b1));
        tick();
        chk("eng_new_single", 640'(eng_new), 640'(1'b0));
    endtask

    task automatic run_job(input int rsp_delay);
        rsp_t e;
        int   wc;
        model(e, wc);
        if (wc < 0) begin
            chk("sched_complete", 640'(wc), 640'(0));
            return;
        end
        rsp_q.push_back(e);
        issue_req();
        fork
            begin
                for (int w = 0; w < W; w++) begin
                    eng_cp_ready = s_ct_v[w];  eng_ct  = s_ct_d[w];
                    eng_tag_ready = s_tag_v[w]; eng_tag = s_tag_d[w];
                    tick();
                end
                eng_cp_ready = 1'b0; eng_tag_ready = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!rsp_valid && w < 40) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    tick();
                    w++;
                end
                chk("rsp_latency", 640'(w), 640'(wc + 1));
                for (int d = 0; d < rsp_delay; d++) begin
                    rsp_ready = 1'b0;
                    chk("req_ready_in_done", 640'(req_ready), 640'(1'b0));
                    tick();
                end
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                chk("req_ready_b2b", 640'({req_ready, busy}), 640'(2'b10));
            end
        join
    endtask

    // Monitor: pops expectations whenever the DUT launches the engine or presents a response.
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_new) begin
                if (op_q.size() == 0) begin
                    chk("unexpected_eng_new", 640'(eng_new), 640'(1'b0));
                end else begin
                    last_op = op_q.pop_front();
                    chk("eng_operands", 640'({eng_key, eng_iv, eng_aad, eng_pt, eng_aad_size, eng_pt_size}), 640'(last_op));
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 640'(rsp_valid), 640'(1'b0));
                end else if (rsp_ready) begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_ct", 640'(rsp_ct), 640'(e.ct));
                    chk("rsp_tag", 640'(rsp_tag), 640'(e.tag));
                    chk("rsp_err", 640'(rsp_err), 640'(e.err));
                    chk("eng_hold", 640'({eng_key, eng_iv, eng_aad, eng_pt, eng_aad_size, eng_pt_size}), 640'(last_op));
                end else begin
                    chk("rsp_stable", 640'({rsp_ct, rsp_tag, rsp_err}), 640'({rsp_q[0].ct, rsp_q[0].tag, rsp_q[0].err}));
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", 640'({req_ready, eng_new, busy, rsp_valid, rsp_err, rsp_ct, rsp_tag}), 640'(0));
        chk("reset_eng", 640'({eng_key, eng_iv, eng_aad, eng_pt, eng_aad_size, eng_pt_size}), 640'(0));
        tick(); tick();
        rst = 1'b0;
        chk("ready_before_edge", 640'(req_ready), 640'(1'b0));
        tick();
        chk("ready_after_rst", 640'(req_ready), 640'(1'b1));

        // Known-answer job: all-zero key/iv/pt, engine replies at N+5.
        op_key = '0; op_iv = '0; op_aad = '0; op_pt = '0; op_aad_size = 64'd0; op_pt_size = 64'd128;
        clear_sched();
        s_ct_v[3] = 1'b1;  s_ct_d[3]  = 128'h0388dace60b6a392f328c2b971b2fe78;
        s_tag_v[3] = 1'b1; s_tag_d[3] = 128'hab6e47d42cec13bdf53a67b21257bddf;
        run_job(0);

        // Tag three cycles ahead of ct.
        random_ops(); clear_sched();
        s_tag_v[0] = 1'b1; s_ct_v[3] = 1'b1;
        run_job(0);

        // Minimum latency: both results in the first WAIT cycle.
        random_ops(); clear_sched();
        s_tag_v[0] = 1'b1; s_ct_v[0] = 1'b1;
        run_job(0);

        // Long response stall followed directly by a second job.
        random_ops(); random_sched();
        run_job(10);
        random_ops(); random_sched();
        run_job(0);

        // Reset during WAIT discards the job.
        random_ops(); clear_sched();
        issue_req();
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("midjob_reset_outputs", 640'({req_ready, eng_new, busy, rsp_valid, rsp_err, rsp_ct, rsp_tag}), 640'(0));
        chk("midjob_reset_eng", 640'({eng_key, eng_iv, eng_aad, eng_pt, eng_aad_size, eng_pt_size}), 640'(0));
        tick(); tick();
        rst = 1'b0;
        chk("midjob_ready_before_edge", 640'(req_ready), 640'(1'b0));
        tick();
        chk("midjob_ready_after", 640'(req_ready), 640'(1'b1));
        random_ops(); random_sched();
        run_job(1);

`ifdef GCM_JOB_CTRL_TIMEOUT_EN
        // Silent engine, then completion exactly on the last allowed cycle.
        random_ops(); clear_sched();
        run_job(2);
        random_ops(); clear_sched();
        s_ct_v[TB_TIMEOUT - 1] = 1'b1; s_tag_v[TB_TIMEOUT - 1] = 1'b1;
        run_job(0);
        random_ops(); clear_sched();
        s_ct_v[2] = 1'b1;
        run_job(0);
`endif

        for (int j = 0; j < 40; j++) begin
            random_ops(); random_sched();
            run_job($urandom_range(0, 4));
        end

        tick(); tick();
        chk("queues_drained", 640'({op_q.size(), rsp_q.size()}), 640'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
